// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the decode bundle, supports stall/flush,
// exposes EX load/rd to the hazard unit and counts bubbles entering EX.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             clr_cnt_i,
  input  logic             id_valid_i,
  input  logic [20:0]      ctrl_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  output logic [20:0]      ctrl_o,
  output logic             valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic             ex_memread_o,
  output logic [4:0]       ex_rd_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_STALL,
    ACT_FLUSH
  } action_e;

  action_e           action;
  logic              bubbleEvent;
  logic [20:0]       ctrlQ;
  logic              validQ;
  logic [XLEN-1:0]   pcQ;
  logic [XLEN-1:0]   rs1DataQ;
  logic [XLEN-1:0]   rs2DataQ;
  logic [XLEN-1:0]   immQ;
  logic [4:0]        rs1AddrQ;
  logic [4:0]        rs2AddrQ;
  logic [CNT_W-1:0]  bubbleCntQ;

  // Flush outranks stall, stall outranks a normal load.
  always_comb begin
    action = ACT_LOAD;
    if (flush_i)      action = ACT_FLUSH;
    else if (stall_i) action = ACT_STALL;
  end

  // A bubble enters EX on any flush, or on a load of an invalid/zero bundle.
  always_comb begin
    bubbleEvent = 1'b0;
    unique case (action)
      ACT_FLUSH: bubbleEvent = 1'b1;
      ACT_LOAD:  bubbleEvent = !id_valid_i || (ctrl_i == '0);
      default:   bubbleEvent = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrlQ    <= '0;
      validQ   <= 1'b0;
      pcQ      <= '0;
      rs1DataQ <= '0;
      rs2DataQ <= '0;
      immQ     <= '0;
      rs1AddrQ <= '0;
      rs2AddrQ <= '0;
    end else begin
      unique case (action)
        ACT_FLUSH: begin
          ctrlQ  <= '0;
          validQ <= 1'b0;
        end
        ACT_LOAD: begin
          ctrlQ    <= id_valid_i ? ctrl_i : '0;
          validQ   <= id_valid_i;
          pcQ      <= pc_i;
          rs1DataQ <= rs1_data_i;
          rs2DataQ <= rs2_data_i;
          immQ     <= imm_i;
          rs1AddrQ <= rs1_addr_i;
          rs2AddrQ <= rs2_addr_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bubbleCntQ <= '0;
    end else if (clr_cnt_i) begin
      bubbleCntQ <= '0;
    end else if (bubbleEvent && (bubbleCntQ != '1)) begin
      bubbleCntQ <= bubbleCntQ + 1'b1;
    end
  end

  assign ctrl_o       = ctrlQ;
  assign valid_o      = validQ;
  assign pc_o         = pcQ;
  assign rs1_data_o   = rs1DataQ;
  assign rs2_data_o   = rs2DataQ;
  assign imm_o        = immQ;
  assign rs1_addr_o   = rs1AddrQ;
  assign rs2_addr_o   = rs2AddrQ;
  assign bubble_cnt_o = bubbleCntQ;

  // Gate with valid so a squashed slot never looks like a live load to hazard logic.
  assign ex_memread_o = ctrlQ[12] & validQ;
  assign ex_rd_o      = validQ ? ctrlQ[20:16] : '0;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode-stage control bubble mux.
- Captures the muxed control bundle and decode-stage operands each cycle and presents them to EX.
- Supports stall (hold) and flush (bubble insert).
- Feeds EX memread/rd back to the load-use hazard detector and counts inserted bubbles for performance monitoring.

Parameters:
- XLEN, 32, width of PC, operand and immediate datapaths.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- stall_i  in  1  hold all registers this cycle.
- flush_i  in  1  squash: load a bubble into EX.
- clr_cnt_i  in  1  synchronous clear of bubble counter.
- id_valid_i  in  1  decode slot holds a real instruction.
- ctrl_i  in  21  packed controls from the bubble mux:
  - [20:16] rd
  - [15] regWrite
  - [14] immSel
  - [13] loadMux
  - [12] memRead
  - [11] memWrite
  - [10] jalr
  - [9] branch
  - [8:5] ALU op
  - [4:3] branch-select
  - [2:0] load/store type
- pc_i  in  XLEN  instruction PC.
- rs1_data_i  in  XLEN  register-file read 1.
- rs2_data_i  in  XLEN  register-file read 2.
- imm_i  in  XLEN  sign-extended immediate.
- rs1_addr_i  in  5  source register 1 index (for forwarding).
- rs2_addr_i  in  5  source register 2 index.
- ctrl_o  out  21  registered control bundle, same packing as ctrl_i.
- valid_o  out  1  EX slot holds a real instruction.
- pc_o  out  XLEN  registered PC.
- rs1_data_o  out  XLEN  registered operand 1.
- rs2_data_o  out  XLEN  registered operand 2.
- imm_o  out  XLEN  registered immediate.
- rs1_addr_o  out  5  registered source index 1.
- rs2_addr_o  out  5  registered source index 2.
- ex_memread_o  out  1  ctrl_o[12] AND valid_o, combinational from registers.
- ex_rd_o  out  5  ctrl_o[20:16] when valid_o, else 0; combinational from registers.
- bubble_cnt_o  out  CNT_W  saturating count of bubbles entering EX.

Behaviour:
- Reset (rst_ni low, asynchronous): every registered output is 0, including valid_o and bubble_cnt_o. Derived outputs are therefore 0.
- Latency: one cycle, ID inputs to EX outputs.
- Per rising edge, priority flush > stall > load:
  - flush_i=1: ctrl_o<=0, valid_o<=0; data/address registers hold. Flush overrides a simultaneous stall.
  - stall_i=1 (no flush): all pipeline registers hold, including ctrl_o and valid_o.
  - Otherwise (load):
    - pc/operands/imm/addresses load from inputs.
    - valid_o<=id_valid_i.
    - ctrl_o<=ctrl_i if id_valid_i=1, else 0.
- Bubble event: an edge where the register loads a bubble. This is any flush, or a load with id_valid_i=0 or ctrl_i==0 (hazard-mux bubble). Stall-hold edges are never bubble events.
- Counter:
  - clr_cnt_i=1 forces bubble_cnt_o<=0 and wins over a simultaneous increment.
  - Otherwise a bubble event increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - The counter is unaffected by stall_i.
- Releasing reset mid-operation: the first edge after deassert behaves as a normal load; no extra bubble is counted for reset.
- ex_memread_o and ex_rd_o must never reflect a flushed or invalid slot.
- No combinational path from any input to any output.

Test Plan:
- Reset with rst_ni low asynchronously mid-cycle, ctrl_i=21'h1FFFFF -> all outputs 0 immediately; after release, one load edge with id_valid_i=1 -> ctrl_o=21'h1FFFFF, valid_o=1.
- Load pc_i=32'h100, rd=5'd7, memRead=1, id_valid_i=1 -> next cycle pc_o=32'h100, ex_memread_o=1, ex_rd_o=7, bubble_cnt_o unchanged.
- With stall_i=1 for 3 cycles while inputs change -> outputs frozen at prior values, bubble_cnt_o unchanged.
- Assert flush_i and stall_i together with valid input -> ctrl_o=0, valid_o=0, ex_rd_o=0, bubble_cnt_o+1, pc_o held.
- Load ctrl_i=0 with id_valid_i=1 (mux bubble) for 4 cycles -> bubble_cnt_o increments by 4.
- With CNT_W=4, drive 20 consecutive bubbles -> bubble_cnt_o saturates at 15; then clr_cnt_i together with flush -> bubble_cnt_o=0.
